// File: rtl/pi_digit_writer.sv
// Resolves raw spigot quotients into final pi digits, packs 8 BCD digits per
// 32-bit word and drives the digit store's write port.
module pi_digit_writer #(
   parameter int ADDR_W     = 14,
   parameter int MAX_DIGITS = 82944,
   parameter int NINE_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_q,
   input  logic              in_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [16:0]       digits_written,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] S_ACCEPT   = 3'd0;
   localparam logic [2:0] S_EMIT_PRE = 3'd1;
   localparam logic [2:0] S_EMIT_RUN = 3'd2;
   localparam logic [2:0] S_FLUSH    = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [16:0]       MAX_IDX   = 17'(MAX_DIGITS);
   localparam logic [NINE_W-1:0] NINES_MAX = {NINE_W{1'b1}};
   localparam logic [31:0]       EMPTY_BUF = 32'hFFFF_FFFF;

   logic [2:0]        state_q, state_d;
   logic [3:0]        pre_q, pre_d;
   logic [NINE_W-1:0] nines_q, nines_d;
   logic              have_pre_q, have_pre_d;
   logic              flush_q, flush_d;
   logic              loaded_q, loaded_d;
   logic [3:0]        emit_pre_q, emit_pre_d;
   logic [NINE_W-1:0] run_cnt_q, run_cnt_d;
   logic [3:0]        run_digit_q, run_digit_d;
   logic [16:0]       idx_q, idx_d;
   logic [31:0]       buf_q, buf_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              xfer;
   logic              emit_valid;
   logic [3:0]        emit_digit;
   logic              start_emit;
   logic [31:0]       word;
   logic [16:0]       idx_next;

   assign in_ready       = (state_q == S_ACCEPT) && !done_q;
   assign xfer           = in_valid && in_ready;
   assign wr_en          = wr_en_q && !rst;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign digits_written = idx_q;
   assign done           = done_q;
   assign err            = err_q;

   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      nines_d     = nines_q;
      have_pre_d  = have_pre_q;
      flush_d     = flush_q;
      loaded_d    = loaded_q;
      emit_pre_d  = emit_pre_q;
      run_cnt_d   = run_cnt_q;
      run_digit_d = run_digit_q;
      idx_d       = idx_q;
      buf_d       = buf_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = done_q;
      err_d       = err_q;
      emit_valid  = 1'b0;
      emit_digit  = 4'd0;
      start_emit  = 1'b0;
      word        = buf_q;
      idx_next    = idx_q + 17'd1;

      case (state_q)
         S_ACCEPT: begin
            if (xfer) begin
               if (in_q > 4'd10) begin
                  err_d = 1'b1;
               end else if (in_q == 4'd9) begin
                  if (nines_q == NINES_MAX) err_d = 1'b1;
                  else nines_d = nines_q + NINE_W'(1);
               end else if (in_q == 4'd10) begin
                  if (!have_pre_q) begin
                     err_d = 1'b1;
                  end else begin
                     // Carry: predigit bumps up, every held nine rolls to zero.
                     emit_pre_d  = pre_q + 4'd1;
                     run_digit_d = 4'd0;
                     run_cnt_d   = nines_q;
                     pre_d       = 4'd0;
                     nines_d     = '0;
                     start_emit  = 1'b1;
                  end
               end else begin
                  if (have_pre_q) begin
                     emit_pre_d  = pre_q;
                     run_digit_d = 4'd9;
                     run_cnt_d   = nines_q;
                     start_emit  = 1'b1;
                  end
                  pre_d      = in_q;
                  nines_d    = '0;
                  have_pre_d = 1'b1;
               end
               if (in_last) flush_d = 1'b1;
               if (start_emit)   state_d = S_EMIT_PRE;
               else if (in_last) state_d = S_FLUSH;
            end
         end
         S_EMIT_PRE: begin
            emit_valid = 1'b1;
            emit_digit = emit_pre_q;
            if (run_cnt_q != '0) state_d = S_EMIT_RUN;
            else                 state_d = flush_q ? S_FLUSH : S_ACCEPT;
         end
         S_EMIT_RUN: begin
            emit_valid = 1'b1;
            emit_digit = run_digit_q;
            run_cnt_d  = run_cnt_q - NINE_W'(1);
            if (run_cnt_q == NINE_W'(1)) state_d = flush_q ? S_FLUSH : S_ACCEPT;
         end
         S_FLUSH: begin
            if (!loaded_q) begin
               // First pass drains the held predigit and nines; second pass writes.
               loaded_d    = 1'b1;
               emit_pre_d  = pre_q;
               run_digit_d = 4'd9;
               run_cnt_d   = nines_q;
               have_pre_d  = 1'b0;
               nines_d     = '0;
               if (have_pre_q)          state_d = S_EMIT_PRE;
               else if (nines_q != '0)  state_d = S_EMIT_RUN;
            end else begin
               if (idx_q[2:0] != 3'd0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ADDR_W'(idx_q >> 3);
                  wr_data_d = buf_q;
                  buf_d     = EMPTY_BUF;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_ACCEPT;
         end
      endcase

      if (emit_valid) begin
         word[{idx_q[2:0], 2'b00} +: 4] = emit_digit;
         buf_d = word;
         idx_d = idx_next;
         if (idx_q[2:0] == 3'd7 || idx_next == MAX_IDX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(idx_q >> 3);
            wr_data_d = word;
            buf_d     = EMPTY_BUF;
         end
         if (idx_next == MAX_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ACCEPT;
         pre_q       <= 4'd0;
         nines_q     <= '0;
         have_pre_q  <= 1'b0;
         flush_q     <= 1'b0;
         loaded_q    <= 1'b0;
         emit_pre_q  <= 4'd0;
         run_cnt_q   <= '0;
         run_digit_q <= 4'd0;
         idx_q       <= 17'd0;
         buf_q       <= EMPTY_BUF;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         nines_q     <= nines_d;
         have_pre_q  <= have_pre_d;
         flush_q     <= flush_d;
         loaded_q    <= loaded_d;
         emit_pre_q  <= emit_pre_d;
         run_cnt_q   <= run_cnt_d;
         run_digit_q <= run_digit_d;
         idx_q       <= idx_d;
         buf_q       <= buf_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_pi_digit_writer.sv
// Directed bench for pi_digit_writer; MAX_DIGITS is shrunk to 16 so the
// store-full boundary is reachable, every other scenario stays below it.
module tb_pi_digit_writer;

   localparam int ADDR_W = 14;
   localparam int MAXD   = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_q = 4'd0;
   logic              in_last = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [16:0]       digits_written;
   logic              done;
   logic              err;

   int checks   = 0;
   int failures = 0;

   // Write log, filled only by the monitor; the stimulus reads it relative to a base.
   int          wr_cnt = 0;
   logic [31:0] log_addr [64];
   logic [31:0] log_data [64];
   int          base = 0;

   pi_digit_writer #(.ADDR_W(ADDR_W), .MAX_DIGITS(MAXD), .NINE_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_q(in_q), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .digits_written(digits_written), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         if (wr_cnt < 64) begin
            log_addr[wr_cnt] = 32'(wr_addr);
            log_data[wr_cnt] = wr_data;
         end
         $display("write addr=%0d data=%08h", wr_addr, wr_data);
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      tick(1);
      rst = 1'b0;
      base = wr_cnt;
   endtask

   task automatic send(input logic [3:0] q, input logic last);
      int t;
      t = 0;
      in_q = q;
      in_last = last;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         tick(1);
         t++;
      end
      check("send_ready_timeout", 32'(t < 200), 32'd1);
      tick(1);
      $display("sent q=%0d last=%0d", q, last);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   initial begin
      int low;
      int t;

      // Reset values
      tick(2);
      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_digits", 32'(digits_written), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Full word: 3,1,4,1,5,9,2,6,5 resolves to 3,1,4,1,5,9,2,6
      send(4'd3, 1'b0); send(4'd1, 1'b0); send(4'd4, 1'b0);
      send(4'd1, 1'b0); send(4'd5, 1'b0); send(4'd9, 1'b0);
      send(4'd2, 1'b0); send(4'd6, 1'b0); send(4'd5, 1'b0);
      tick(4);
      check("w1_count", 32'(wr_cnt - base), 32'd1);
      check("w1_addr", log_addr[base], 32'd0);
      check("w1_data", log_data[base], 32'h62951413);
      check("w1_digits", 32'(digits_written), 32'd8);
      check("w1_data_held", wr_data, 32'h62951413);
      check("w1_done", 32'(done), 32'd0);

      // Carry through nines and flush: 1,9,9,10,4(last) -> 2,0,0,0,4
      do_reset();
      send(4'd1, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0);
      send(4'd10, 1'b0); send(4'd4, 1'b1);
      t = 0;
      while (!done && t < 50) begin
         tick(1);
         t++;
      end
      check("fl_done", 32'(done), 32'd1);
      tick(2);
      check("fl_count", 32'(wr_cnt - base), 32'd1);
      check("fl_addr", log_addr[base], 32'd0);
      check("fl_data", log_data[base], 32'hFFF40002);
      check("fl_digits", 32'(digits_written), 32'd5);
      check("fl_err", 32'(err), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd0);

      // 2,10 is a legal carry; a 10 straight after reset is an error
      do_reset();
      send(4'd2, 1'b0); send(4'd10, 1'b0);
      tick(3);
      check("c_err_legal", 32'(err), 32'd0);
      check("c_digits", 32'(digits_written), 32'd1);
      do_reset();
      send(4'd10, 1'b0);
      tick(3);
      check("c_err_nopre", 32'(err), 32'd1);
      check("c_nopre_digits", 32'(digits_written), 32'd0);
      check("c_nopre_ready", 32'(in_ready), 32'd1);
      do_reset();
      send(4'd11, 1'b0);
      tick(2);
      check("c_err_q11", 32'(err), 32'd1);
      check("c_q11_digits", 32'(digits_written), 32'd0);

      // Backpressure: predigit 1, five nines, resolved by 3 -> 6 stall cycles
      do_reset();
      send(4'd1, 1'b0);
      for (int i = 0; i < 5; i++) send(4'd9, 1'b0);
      in_q = 4'd3;
      in_valid = 1'b1;
      tick(1);
      in_q = 4'd0;
      low = 0;
      while (!in_ready && low < 50) begin
         low++;
         tick(1);
      end
      tick(1);
      in_valid = 1'b0;
      check("bp_low_cycles", 32'(low), 32'd6);
      check("bp_digits", 32'(digits_written), 32'd6);

      // Store-full boundary: digits i%9, capped at 16
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (!done) begin
            send(4'(i % 9), 1'b0);
            tick(2);
         end
      end
      in_q = 4'd1;
      in_valid = 1'b1;
      tick(10);
      in_valid = 1'b0;
      check("mx_count", 32'(wr_cnt - base), 32'd2);
      check("mx_addr0", log_addr[base], 32'd0);
      check("mx_data0", log_data[base], 32'h76543210);
      check("mx_addr1", log_addr[base + 1], 32'd1);
      check("mx_data1", log_data[base + 1], 32'h65432108);
      check("mx_done", 32'(done), 32'd1);
      check("mx_in_ready", 32'(in_ready), 32'd0);
      check("mx_digits", 32'(digits_written), 32'd16);

      // Reset during EMIT_RUN aborts cleanly
      do_reset();
      send(4'd1, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0);
      send(4'd3, 1'b0);
      tick(1);
      check("ab_pre_digits", 32'(digits_written), 32'd1);
      rst = 1'b1;
      tick(1);
      check("ab_in_ready", 32'(in_ready), 32'd1);
      check("ab_wr_en", 32'(wr_en), 32'd0);
      check("ab_digits", 32'(digits_written), 32'd0);
      check("ab_done", 32'(done), 32'd0);
      check("ab_err", 32'(err), 32'd0);
      check("ab_wr_data", wr_data, 32'd0);
      rst = 1'b0;
      base = wr_cnt;
      tick(6);
      check("ab_no_write", 32'(wr_cnt - base), 32'd0);
      check("ab_idle_digits", 32'(digits_written), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
